// File: rtl/key_counter_ctrl.sv
// rtl/key_counter_ctrl.sv - debounced push-button up/down counter with hold-to-repeat and hex scan display
module key_counter_ctrl #(
  parameter int F_CLK           = 50000000,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int WRAP            = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_key,
  output logic [CNT_W-1:0] o_count,
  output logic             o_limit,
  output logic [7:0]       o_cs,
  output logic [7:0]       o_dig_sel
);

  localparam int TICK_DIV = F_CLK / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int ND       = (CNT_W + 3) / 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sync1, sync2, stable, stable_d, arm, press;
  logic [DB_W-1:0] db_cnt [4];
  logic [1:0]      boot;
  logic [HW-1:0]   hold   [2];
  logic [HW-1:0]   target [2];
  logic [1:0]      rptg, rep;
  logic            up_req, dn_req, clr_req;
  logic            disp_en, en_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [31:0]     cnt_ext;
  logic [3:0]      nib;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tick_cnt <= '0;
    else          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // A key held through reset stays disarmed until its synced level is seen released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      boot     <= '0;
      arm      <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      sync1    <= i_key;
      sync2    <= sync1;
      stable_d <= stable;
      boot     <= {boot[0], 1'b1};
      arm      <= arm | ({4{boot[1]}} & stable & sync2);
      if (tick) begin
        for (int k = 0; k < 4; k++) begin
          if (sync2[k] != stable[k]) begin
            if (db_cnt[k] == DB_W'(DEBOUNCE_MS - 1)) begin
              stable[k] <= sync2[k];
              db_cnt[k] <= '0;
            end else begin
              db_cnt[k] <= db_cnt[k] + 1'b1;
            end
          end else begin
            db_cnt[k] <= '0;
          end
        end
      end
    end
  end

  assign press = arm & stable_d & ~stable;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      target[k] = rptg[k] ? HW'(REPEAT_RATE_MS) : HW'(REPEAT_DELAY_MS);
      rep[k]    = arm[k] & ~stable[k] & tick & (hold[k] == target[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rptg <= '0;
      for (int k = 0; k < 2; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (stable[k]) begin
          hold[k] <= '0;
          rptg[k] <= 1'b0;
        end else if (tick) begin
          if (hold[k] == target[k]) begin
            hold[k] <= HW'(1);
            rptg[k] <= 1'b1;
          end else begin
            hold[k] <= hold[k] + 1'b1;
          end
        end
      end
    end
  end

  assign up_req  = press[0] | rep[0];
  assign dn_req  = press[1] | rep[1];
  assign clr_req = press[2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_limit <= 1'b0;
    end else begin
      o_limit <= 1'b0;
      if (clr_req) begin
        o_count <= '0;
      end else if (up_req && !dn_req) begin
        if (o_count == CNT_MAX) begin
          o_limit <= 1'b1;
          if (WRAP != 0) o_count <= '0;
        end else begin
          o_count <= o_count + 1'b1;
        end
      end else if (dn_req && !up_req) begin
        if (o_count == '0) begin
          o_limit <= 1'b1;
          if (WRAP != 0) o_count <= CNT_MAX;
        end else begin
          o_count <= o_count - 1'b1;
        end
      end
    end
  end

  // Outputs are registered from the next pointer so select and segments move together.
  always_comb begin
    en_nxt  = disp_en ^ press[3];
    ptr_nxt = ptr;
    if (!en_nxt || !disp_en) ptr_nxt = 3'd0;
    else if (tick)           ptr_nxt = (ptr == 3'(ND - 1)) ? 3'd0 : ptr + 3'd1;
  end

  assign cnt_ext = 32'(o_count);
  assign nib     = cnt_ext[{ptr_nxt, 2'b00} +: 4];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_en   <= 1'b1;
      ptr       <= 3'd0;
      o_cs      <= 8'hFE;
      o_dig_sel <= 8'hC0;
    end else begin
      disp_en <= en_nxt;
      ptr     <= ptr_nxt;
      if (en_nxt) begin
        o_cs      <= ~(8'd1 << ptr_nxt);
        o_dig_sel <= hex7(nib);
      end else begin
        o_cs      <= 8'hFF;
        o_dig_sel <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_key_counter_ctrl.sv
// tb/tb_key_counter_ctrl.sv - directed bench for key_counter_ctrl, saturating and wrapping instances
module tb_key_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [7:0] count0, count1, cs0, cs1, seg0, seg1;
  logic       limit0, limit1;
  int         errors = 0, checks = 0, cyc = 0;
  int         lim0 = 0, lim1 = 0, ev0 = 0;
  logic [7:0] prev0 = 8'h00;

  key_counter_ctrl #(.F_CLK(1000), .CNT_W(8), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
                     .REPEAT_RATE_MS(3), .WRAP(0)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .o_count(count0), .o_limit(limit0),
    .o_cs(cs0), .o_dig_sel(seg0));

  key_counter_ctrl #(.F_CLK(1000), .CNT_W(8), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
                     .REPEAT_RATE_MS(3), .WRAP(1)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .o_count(count1), .o_limit(limit1),
    .o_cs(cs1), .o_dig_sel(seg1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (limit0) lim0 <= lim0 + 1;
    if (limit1) lim1 <= lim1 + 1;
    if (count0 != prev0) ev0 <= ev0 + 1;
    prev0 <= count0;
  end

  typedef struct {
    logic [3:0] m;
    int         c0;
    int         c1;
    int         l0;
    int         l1;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clean press of the keys in m (bit set = pressed), long enough to debounce, short of repeat.
  task automatic press(input logic [3:0] m);
    @(negedge clk);
    key = ~m;
    repeat (8) @(negedge clk);
    key = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_cnt(input int v, input int budget, output int stamp);
    int n = 0;
    while (int'(count0) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    stamp = cyc;
    check("wait_cnt", int'(count0), v);
  endtask

  task automatic set_count(input int target);
    int n = 0;
    if (int'(count0) < target - 8) begin
      key = 4'b1110;
      while (int'(count0) < target - 8 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      key = 4'hF;
      repeat (15) @(negedge clk);
    end
    n = 0;
    while (int'(count0) < target && n < 20) begin
      press(4'b0001);
      n++;
    end
    while (int'(count0) > target && n < 40) begin
      press(4'b0010);
      n++;
    end
    check("set_count", int'(count0), target);
  endtask

  initial begin
    int lb0, lb1, e0, t0, t, a;
    logic [7:0] pcs;

    tbl[0] = '{4'b0001, 1,   1, 0, 0};
    tbl[1] = '{4'b0001, 2,   2, 0, 0};
    tbl[2] = '{4'b0010, 1,   1, 0, 0};
    tbl[3] = '{4'b0011, 1,   1, 0, 0};
    tbl[4] = '{4'b0101, 0,   0, 0, 0};
    tbl[5] = '{4'b0010, 0, 255, 1, 1};
    tbl[6] = '{4'b0100, 0,   0, 0, 0};
    tbl[7] = '{4'b0110, 0,   0, 0, 0};
    tbl[8] = '{4'b0001, 1,   1, 0, 0};
    tbl[9] = '{4'b0111, 0,   0, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_count", int'(count0), 0);
    check("rst_limit", int'(limit0), 0);
    check("rst_cs", int'(cs0), 8'hFE);
    check("rst_seg", int'(seg0), 8'hC0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      lb0 = lim0;
      lb1 = lim1;
      press(tbl[i].m);
      check($sformatf("vec%0d_count_sat", i), int'(count0), tbl[i].c0);
      check($sformatf("vec%0d_count_wrap", i), int'(count1), tbl[i].c1);
      check($sformatf("vec%0d_limit_sat", i), lim0 - lb0, tbl[i].l0);
      check($sformatf("vec%0d_limit_wrap", i), lim1 - lb1, tbl[i].l1);
    end

    // Bounce shorter than the debounce window, then a real press.
    e0 = ev0;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (2) @(negedge clk);
    end
    key = 4'b1110;
    repeat (6) @(negedge clk);
    key = 4'hF;
    repeat (15) @(negedge clk);
    check("bounce_count", int'(count0), 1);
    check("bounce_events", ev0 - e0, 1);

    press(4'b0100);
    key = 4'b1110;
    wait_cnt(1, 50, t0);
    for (int v = 2; v <= 8; v++) begin
      wait_cnt(v, 20, t);
      check($sformatf("hold_step%0d", v), t - t0, 10 + 3 * (v - 2));
    end
    key = 4'hF;
    repeat (30) @(negedge clk);
    a = int'(count0);
    repeat (20) @(negedge clk);
    check("hold_release_stops", int'(count0), a);

    press(4'b0100);
    set_count(255);
    check("max_wrap_count", int'(count1), 255);
    lb0 = lim0;
    lb1 = lim1;
    press(4'b0001);
    check("sat_up_count", int'(count0), 255);
    check("wrap_up_count", int'(count1), 0);
    check("sat_up_limit", lim0 - lb0, 1);
    check("wrap_up_limit", lim1 - lb1, 1);

    press(4'b0100);
    set_count(8'hA5);
    @(negedge clk);
    pcs = cs0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("scan_cs", int'(cs0), (pcs == 8'hFE) ? 8'hFD : 8'hFE);
      check("scan_seg", int'(seg0), (cs0 == 8'hFE) ? 8'h92 : 8'h88);
      pcs = cs0;
    end
    press(4'b1000);
    check("dark_cs", int'(cs0), 8'hFF);
    check("dark_seg", int'(seg0), 8'hFF);
    key = 4'b0111;
    a = 0;
    while (cs0 == 8'hFF && a < 20) begin
      @(negedge clk);
      a++;
    end
    check("resume_cs", int'(cs0), 8'hFE);
    check("resume_seg", int'(seg0), 8'h92);
    key = 4'hF;
    repeat (15) @(negedge clk);

    key = 4'b1110;
    a = 0;
    while (int'(count0) < 8'hA5 + 3 && a < 100) begin
      @(negedge clk);
      a++;
    end
    check("pre_reset_repeat", int'(count0) >= 8'hA8 ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_count_sat", int'(count0), 0);
    check("midrst_count_wrap", int'(count1), 0);
    check("midrst_limit", int'(limit0), 0);
    check("midrst_cs", int'(cs1), 8'hFE);
    check("midrst_seg", int'(seg1), 8'hC0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("held_after_reset", int'(count0), 0);
    key = 4'hF;
    repeat (15) @(negedge clk);
    press(4'b0001);
    check("repress_after_reset", int'(count0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
